ex_mem: RTL and testbench
=========================

EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the width of ex_/mem_ memaddr, memdata and wdata.
REQ-002 Parameter REG_W, default 4, SHALL set the width of ex_waddr and mem_waddr.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset sampled on the clk rising edge.
REQ-005 stall  input  1  SHALL mean: 1 = hold all registered outputs; 0 = advance.
REQ-006 ex_memrw  input  2  SHALL carry the EX-stage memory op: 2'b00 Idle, 2'b01 Read, 2'b10 Write, 2'b11 reserved.
REQ-007 ex_memaddr  input  DATA_W  SHALL carry the memory address.
REQ-008 ex_memdata  input  DATA_W  SHALL carry the store data.
REQ-009 ex_wdata  input  DATA_W  SHALL carry the register write-back value.
REQ-010 ex_waddr  input  REG_W  SHALL carry the destination register index.
REQ-011 ex_we  input  1  SHALL carry register write enable (1 = write).
REQ-012 mem_memrw, mem_memaddr, mem_memdata, mem_wdata, mem_waddr, mem_we  output  same widths as ex_ counterparts  SHALL be the registered MEM-stage copies.
REQ-013 flush  input  1  SHALL exist only when EX_MEM_FLUSH_EN is defined (see Configuration).

Function
REQ-014 All outputs SHALL be driven directly from flip-flops; no combinational input-to-output path.
REQ-015 On a rising edge with rst=0 and stall=0, every mem_* output SHALL take its ex_* input value (latency 1 cycle).
REQ-016 On a rising edge with rst=0 and stall=1, every mem_* output SHALL keep its previous value; inputs are ignored.
REQ-017 ex_memrw=2'b11 SHALL be captured as 2'b00 (Idle); the other memrw fields are captured unchanged.
REQ-018 mem_waddr and mem_wdata SHALL be captured as-is even when ex_we=0; no masking.
REQ-019 Priority on any edge SHALL be rst > flush (if compiled) > stall > normal capture.
REQ-020 Stall held for N consecutive edges SHALL freeze outputs for N edges; the first edge with stall=0 captures the current inputs.

Reset
REQ-021 When rst=1 at a rising edge, outputs SHALL become: mem_memrw=2'b00, mem_memaddr=0, mem_memdata=0, mem_wdata=0, mem_waddr=0, mem_we=0, regardless of stall, flush and inputs.
REQ-022 Reset asserted mid-stall SHALL clear the outputs at that edge; no held value survives.
REQ-023 Outputs before the first reset edge are undefined.

Configuration
REQ-024 With macro EX_MEM_FLUSH_EN defined, port flush SHALL exist; flush=1 (rst=0) at a rising edge SHALL load the reset values of REQ-021 (bubble), overriding stall.
REQ-025 Without EX_MEM_FLUSH_EN, port flush SHALL be absent and behaviour SHALL be exactly REQ-014..REQ-023.

Verification
REQ-026 rst=1 for one edge with all inputs 0 -> all outputs 0, mem_memrw=00, mem_we=0.
REQ-027 rst=0, stall=0, ex_wdata=1, ex_waddr=1, ex_we=1, memrw=00 -> after one edge mem_wdata=1, mem_waddr=1, mem_we=1, mem_memrw=00.
REQ-028 Next: ex_we=0, waddr=0, wdata=0, memrw=10, memaddr=2, memdata=2 -> mem_memrw=10, mem_memaddr=2, mem_memdata=2, mem_we=0.
REQ-029 stall=1 with inputs memrw=01, memaddr=2, memdata=0, waddr=1, wdata=0, we=1 -> outputs unchanged from REQ-028; after stall=0 and one edge -> mem_memrw=01, mem_memaddr=2, mem_memdata=0, mem_waddr=1, mem_we=1.
REQ-030 rst=1 while stall=1 and nonzero outputs -> all outputs zero after one edge; ex_memrw=11 captured -> mem_memrw=00.
REQ-031 With EX_MEM_FLUSH_EN: flush=1 and stall=1 with nonzero outputs -> outputs reset values after one edge; flush=0 next edge -> normal capture resumes.

Source files
------------

// File: rtl/ex_mem.sv
// ex_mem: EX->MEM pipeline register for memory op, address, store data and write-back fields.
// Latency: 1 cycle from ex_* to mem_*; every output comes straight from a flop.
// Backpressure: stall=1 freezes the stage; optional flush (macro EX_MEM_FLUSH_EN) loads a bubble.
module ex_mem #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
`ifdef EX_MEM_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              stall,
  input  logic [1:0]        ex_memrw,
  input  logic [DATA_W-1:0] ex_memaddr,
  input  logic [DATA_W-1:0] ex_memdata,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [REG_W-1:0]  ex_waddr,
  input  logic              ex_we,
  output logic [1:0]        mem_memrw,
  output logic [DATA_W-1:0] mem_memaddr,
  output logic [DATA_W-1:0] mem_memdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [REG_W-1:0]  mem_waddr,
  output logic              mem_we
);

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_RSVD = 2'b11;

  // Whole stage payload as one bus so reset/bubble is a single '0 load.
  typedef struct packed {
    logic [1:0]        memrw;
    logic [DATA_W-1:0] memaddr;
    logic [DATA_W-1:0] memdata;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  waddr;
    logic              we;
  } stage_t;

  stage_t cap;
  stage_t stage_q;

  // Capture value: inputs as-is, except the reserved op is folded to idle.
  // waddr/wdata pass through even when we=0; downstream qualifies on we.
  always_comb begin
    cap         = '0;
    cap.memrw   = (ex_memrw == OP_RSVD) ? OP_IDLE : ex_memrw;
    cap.memaddr = ex_memaddr;
    cap.memdata = ex_memdata;
    cap.wdata   = ex_wdata;
    cap.waddr   = ex_waddr;
    cap.we      = ex_we;
  end

  // Stage register, priority rst > flush > stall > capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end
`ifdef EX_MEM_FLUSH_EN
    else if (flush) begin
      stage_q <= '0;
    end
`endif
    else if (!stall) begin
      stage_q <= cap;
    end
  end

  assign mem_memrw   = stage_q.memrw;
  assign mem_memaddr = stage_q.memaddr;
  assign mem_memdata = stage_q.memdata;
  assign mem_wdata   = stage_q.wdata;
  assign mem_waddr   = stage_q.waddr;
  assign mem_we      = stage_q.we;

endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem: scoreboard bench for the ex_mem pipeline register.
// Latency: expects outputs one clk edge after inputs are applied.
// Backpressure: exercises stall holds, reset during stall and (if compiled) flush bubbles.
module tb_ex_mem;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  typedef struct packed {
    logic [1:0]        memrw;
    logic [DATA_W-1:0] memaddr;
    logic [DATA_W-1:0] memdata;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  waddr;
    logic              we;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              stall;
  logic [1:0]        ex_memrw;
  logic [DATA_W-1:0] ex_memaddr;
  logic [DATA_W-1:0] ex_memdata;
  logic [DATA_W-1:0] ex_wdata;
  logic [REG_W-1:0]  ex_waddr;
  logic              ex_we;
  logic [1:0]        mem_memrw;
  logic [DATA_W-1:0] mem_memaddr;
  logic [DATA_W-1:0] mem_memdata;
  logic [DATA_W-1:0] mem_wdata;
  logic [REG_W-1:0]  mem_waddr;
  logic              mem_we;
`ifdef EX_MEM_FLUSH_EN
  logic              flush;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t model;
  exp_t exp_v;
  exp_t obs;

  ex_mem #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef EX_MEM_FLUSH_EN
    .flush       (flush),
`endif
    .stall       (stall),
    .ex_memrw    (ex_memrw),
    .ex_memaddr  (ex_memaddr),
    .ex_memdata  (ex_memdata),
    .ex_wdata    (ex_wdata),
    .ex_waddr    (ex_waddr),
    .ex_we       (ex_we),
    .mem_memrw   (mem_memrw),
    .mem_memaddr (mem_memaddr),
    .mem_memdata (mem_memdata),
    .mem_wdata   (mem_wdata),
    .mem_waddr   (mem_waddr),
    .mem_we      (mem_we)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [1:0] rw, input logic [DATA_W-1:0] a,
                              input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] wd,
                              input logic [REG_W-1:0] wa, input logic w);
    exp_t e;
    e = '{memrw: rw, memaddr: a, memdata: d, wdata: wd, waddr: wa, we: w};
    return e;
  endfunction

  function automatic exp_t observe();
    return mk(mem_memrw, mem_memaddr, mem_memdata, mem_wdata, mem_waddr, mem_we);
  endfunction

  // Apply stimulus for the next edge (called just after an edge).
  task automatic set_in(input logic r, input logic s, input logic [1:0] rw,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [DATA_W-1:0] wd, input logic [REG_W-1:0] wa,
                        input logic w);
    rst = r; stall = s; ex_memrw = rw; ex_memaddr = a; ex_memdata = d;
    ex_wdata = wd; ex_waddr = wa; ex_we = w;
  endtask

  // Push an expectation, advance one edge, and sample 1 time unit later.
  task automatic push_step(input exp_t e);
    sb_q.push_back(e);
    model = e;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Reset must win over stall and nonzero inputs, even from X state.
    set_in(1'b1, 1'b1, 2'b10, 16'hdead, 16'hbeef, 16'h1234, 4'hf, 1'b1);
    push_step(mk(2'b00, '0, '0, '0, '0, 1'b0));
    obs = observe(); exp_v = sb_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_over_stall: got %h expected %h", obs, exp_v);
    end
    set_in(1'b1, 1'b0, 2'b00, '0, '0, '0, '0, 1'b0);
    push_step(mk(2'b00, '0, '0, '0, '0, 1'b0));
    obs = observe(); exp_v = sb_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_zero: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_capture();
    set_in(1'b0, 1'b0, 2'b00, '0, '0, 16'd1, 4'd1, 1'b1);
    push_step(mk(2'b00, '0, '0, 16'd1, 4'd1, 1'b1));
    obs = observe(); exp_v = sb_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL capture_regwrite: got %h expected %h", obs, exp_v);
    end
    set_in(1'b0, 1'b0, 2'b10, 16'd2, 16'd2, 16'd0, 4'd0, 1'b0);
    push_step(mk(2'b10, 16'd2, 16'd2, 16'd0, 4'd0, 1'b0));
    obs = observe(); exp_v = sb_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL capture_store: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_stall();
    exp_t held;
    held = model;
    // Three stalled edges with changing inputs: outputs stay frozen.
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, 2'b01, 16'd2 + 16'(i), 16'd0, 16'd0, 4'd1, 1'b1);
      push_step(held);
      obs = observe(); exp_v = sb_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL stall_hold_%0d: got %h expected %h", i, obs, exp_v);
      end
    end
    set_in(1'b0, 1'b0, 2'b01, 16'd2, 16'd0, 16'd0, 4'd1, 1'b1);
    push_step(mk(2'b01, 16'd2, 16'd0, 16'd0, 4'd1, 1'b1));
    obs = observe(); exp_v = sb_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL stall_release: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_reset_in_stall();
    set_in(1'b0, 1'b0, 2'b10, 16'h5a5a, 16'ha5a5, 16'h0f0f, 4'h9, 1'b1);
    push_step(mk(2'b10, 16'h5a5a, 16'ha5a5, 16'h0f0f, 4'h9, 1'b1));
    obs = observe(); exp_v = sb_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL preload_nonzero: got %h expected %h", obs, exp_v);
    end
    set_in(1'b1, 1'b1, 2'b01, 16'h1111, 16'h2222, 16'h3333, 4'h4, 1'b1);
    push_step(mk(2'b00, '0, '0, '0, '0, 1'b0));
    obs = observe(); exp_v = sb_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_mid_stall: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_reserved_and_nomask();
    // Reserved op folds to idle; other fields still captured.
    set_in(1'b0, 1'b0, 2'b11, 16'h00aa, 16'h00bb, 16'h00cc, 4'h7, 1'b1);
    push_step(mk(2'b00, 16'h00aa, 16'h00bb, 16'h00cc, 4'h7, 1'b1));
    obs = observe(); exp_v = sb_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reserved_op: got %h expected %h", obs, exp_v);
    end
    // we=0 must not mask waddr/wdata.
    set_in(1'b0, 1'b0, 2'b01, 16'hffff, 16'h8001, 16'hc3c3, 4'he, 1'b0);
    push_step(mk(2'b01, 16'hffff, 16'h8001, 16'hc3c3, 4'he, 1'b0));
    obs = observe(); exp_v = sb_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL no_mask_we0: got %h expected %h", obs, exp_v);
    end
  endtask

`ifdef EX_MEM_FLUSH_EN
  task automatic test_flush();
    set_in(1'b0, 1'b0, 2'b10, 16'h4321, 16'h8765, 16'h0abc, 4'h3, 1'b1);
    push_step(mk(2'b10, 16'h4321, 16'h8765, 16'h0abc, 4'h3, 1'b1));
    obs = observe(); exp_v = sb_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL flush_preload: got %h expected %h", obs, exp_v);
    end
    flush = 1'b1;
    set_in(1'b0, 1'b1, 2'b01, 16'h1, 16'h2, 16'h3, 4'h4, 1'b1);
    push_step(mk(2'b00, '0, '0, '0, '0, 1'b0));
    obs = observe(); exp_v = sb_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL flush_over_stall: got %h expected %h", obs, exp_v);
    end
    flush = 1'b0;
    set_in(1'b0, 1'b0, 2'b01, 16'h1, 16'h2, 16'h3, 4'h4, 1'b1);
    push_step(mk(2'b01, 16'h1, 16'h2, 16'h3, 4'h4, 1'b1));
    obs = observe(); exp_v = sb_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL flush_resume: got %h expected %h", obs, exp_v);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic              r, s;
    logic [1:0]        rw;
    logic [DATA_W-1:0] a, d, wd;
    logic [REG_W-1:0]  wa;
    logic              w;
    exp_t              nxt;
    for (int i = 0; i < 40; i++) begin
      r  = ($urandom_range(0, 15) == 0);
      s  = ($urandom_range(0, 3) == 0);
      rw = 2'($urandom_range(0, 3));
      a  = 16'($urandom);
      d  = 16'($urandom);
      wd = 16'($urandom);
      wa = 4'($urandom);
      w  = 1'($urandom);
      if (r)      nxt = mk(2'b00, '0, '0, '0, '0, 1'b0);
      else if (s) nxt = model;
      else        nxt = mk((rw == 2'b11) ? 2'b00 : rw, a, d, wd, wa, w);
      set_in(r, s, rw, a, d, wd, wa, w);
      push_step(nxt);
      if (sb_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL b2b_queue_empty: got size 0 expected 1");
      end else begin
        obs = observe(); exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL b2b_%0d: got %h expected %h (rst=%b stall=%b rw=%b)",
                   i, obs, exp_v, r, s, rw);
        end
      end
    end
  endtask

  // Test sequence.
  initial begin
`ifdef EX_MEM_FLUSH_EN
    flush = 1'b0;
`endif
    model = '0;
    set_in(1'b0, 1'b0, 2'b00, '0, '0, '0, '0, 1'b0);
    test_reset();
    test_capture();
    test_stall();
    test_reset_in_stall();
    test_reserved_and_nomask();
`ifdef EX_MEM_FLUSH_EN
    test_flush();
`endif
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
